// File: rtl/mem_stage_if.sv
// EX->MEM->WB/ID bus bundle for the MIPS memory-access stage.
// The master drives the EX bus, SRAM response and pipeline control; the slave is mem_stage.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 178,
  parameter int MEM_TO_WB_WD = 174
);
  logic                    flush;
  logic [5:0]              stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic                    data_sram_rvalid;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id_fwd;
  logic                    stall_req_mem;

  modport master (
    output flush, stall, ex_to_mem_bus, data_sram_rvalid, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_fwd, stall_req_mem
  );

  modport slave (
    input  flush, stall, ex_to_mem_bus, data_sram_rvalid, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_fwd, stall_req_mem
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX bus, waits on variable-latency load data, aligns/extends it.
// Optional macro MEM_UNALIGNED_EXC_EN raises AdEL for misaligned lh/lhu/lw instead of loading.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 178,
  parameter int MEM_TO_WB_WD = 174,
  parameter int LD_ADDR_LSB  = 0
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus_if
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q;
  logic [EX_TO_MEM_WD-1:0] reg_q;
  logic [EX_TO_MEM_WD-1:0] reg_d;
  logic [31:0]             buf_q;
  logic                    reg_load;

  logic [2:0]  ld_op;
  logic        mem_wait;
  logic [31:0] addr;
  logic [1:0]  a;
  logic        unaligned;
  logic        load_pend;
  logic        stall_req;
  logic        bypass;
  logic [31:0] src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic        rf_we_out;
  logic [31:0] rf_wdata_out;
  logic [4:0]  exc_out;
  logic [31:0] badv_out;
  logic        unused_ok;

  assign mem_wait = reg_q[177];
  assign ld_op    = reg_q[176:174];
  assign addr     = reg_q[LD_ADDR_LSB +: 32];
  assign a        = addr[1:0];

`ifdef MEM_UNALIGNED_EXC_EN
  assign unaligned = (ld_op != 3'b000) && mem_wait &&
                     ((((ld_op == 3'b011) || (ld_op == 3'b100)) && a[0]) ||
                      ((ld_op >= 3'b101) && (a != 2'b00)));
`else
  assign unaligned = 1'b0;
`endif

  assign load_pend = (ld_op != 3'b000) && mem_wait && !unaligned;
  assign stall_req = load_pend && (state_q != S_DONE) && !bus_if.data_sram_rvalid;
  // Same-cycle response bypasses the buffer so the stall drops immediately.
  assign bypass    = load_pend && (state_q != S_DONE) && bus_if.data_sram_rvalid;
  assign src       = bypass ? bus_if.data_sram_rdata : buf_q;
  assign byte_sel  = src[{a, 3'b000} +: 8];
  assign half_sel  = a[1] ? src[31:16] : src[15:0];

  always_comb begin
    ld_data = src;
    case (ld_op)
      3'b001:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  ld_data = {24'h0, byte_sel};
      3'b011:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {16'h0, half_sel};
      default: ld_data = src;
    endcase
  end

  assign reg_load = bus_if.flush || !bus_if.stall[3] || !bus_if.stall[4];
  assign reg_d    = (bus_if.flush || bus_if.stall[3]) ? '0 : bus_if.ex_to_mem_bus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q   <= '0;
      buf_q   <= '0;
      state_q <= S_IDLE;
    end else if (reg_load) begin
      reg_q   <= reg_d;
      buf_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (load_pend) begin
          if (bus_if.data_sram_rvalid) begin
            buf_q   <= bus_if.data_sram_rdata;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: if (load_pend && bus_if.data_sram_rvalid) begin
          buf_q   <= bus_if.data_sram_rdata;
          state_q <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign rf_we_out    = reg_q[37] && !stall_req && !unaligned;
  assign rf_wdata_out = load_pend ? ld_data : reg_q[31:0];
  assign exc_out      = unaligned ? 5'h04 : reg_q[140:136];
  assign badv_out     = unaligned ? addr : reg_q[173:142];

  assign bus_if.mem_to_wb_bus = {badv_out, reg_q[141], exc_out, reg_q[135:38],
                                 rf_we_out, reg_q[36:32], rf_wdata_out};
  assign bus_if.mem_to_id_fwd = {rf_we_out, reg_q[36:32], rf_wdata_out};
  assign bus_if.stall_req_mem = stall_req;

  assign unused_ok = ^{bus_if.stall[5], bus_if.stall[2:0]};
endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: load latency, alignment, stall/flush/reset behaviour.
module tb_mem_stage;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  mem_stage_if #(.EX_TO_MEM_WD(178), .MEM_TO_WB_WD(174)) bif ();

  mem_stage #(.EX_TO_MEM_WD(178), .MEM_TO_WB_WD(174), .LD_ADDR_LSB(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [177:0] mk(input logic [2:0] op, input logic mw,
                                      input logic [31:0] wdata, input logic [4:0] waddr);
    logic [177:0] b;
    b = '0;
    b[177]     = mw;
    b[176:174] = op;
    b[69:38]   = 32'hBFC0_0100;
    b[37]      = 1'b1;
    b[36:32]   = waddr;
    b[31:0]    = wdata;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [177:0] b);
    bif.stall         = 6'b000000;
    bif.ex_to_mem_bus = b;
    tick();
    bif.ex_to_mem_bus = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.flush = 1'b0; bif.stall = '0; bif.ex_to_mem_bus = '0;
    bif.data_sram_rvalid = 1'b0; bif.data_sram_rdata = '0;
    #12;
    total_cnt++;
    if (bif.mem_to_wb_bus !== '0 || bif.mem_to_id_fwd !== '0 || bif.stall_req_mem !== 1'b0)
      $display("FAIL reset_outputs: wb=%h fwd=%h req=%b required all 0",
               bif.mem_to_wb_bus, bif.mem_to_id_fwd, bif.stall_req_mem);
    else begin pass_cnt++; $display("ok   reset_outputs"); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_byte_wait();
    enter(mk(3'b010, 1'b1, 32'h0000_1001, 5'd5));
    bif.stall = 6'b011111;
    #2 chk("lbu_stall_c0", {31'h0, bif.stall_req_mem}, 32'h1);
    chk("lbu_rfwe_masked", {31'h0, bif.mem_to_wb_bus[37]}, 32'h0);
    tick();
    #2 chk("lbu_stall_c1", {31'h0, bif.stall_req_mem}, 32'h1);
    tick();
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'h80FF_1234;
    #2 chk("lbu_stall_drop", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("lbu_wdata", bif.mem_to_wb_bus[31:0], 32'h0000_0012);
    chk("lbu_rfwe", {31'h0, bif.mem_to_wb_bus[37]}, 32'h1);
    chk("lbu_fwd", {26'h0, bif.mem_to_id_fwd[37:32]}, {26'h0, 1'b1, 5'd5});
    bif.stall = '0;
    tick();
    bif.data_sram_rvalid = 1'b0;

    enter(mk(3'b001, 1'b1, 32'h0000_1003, 5'd6));
    bif.stall = 6'b011111;
    #2 chk("lb_stall_c0", {31'h0, bif.stall_req_mem}, 32'h1);
    tick(); tick();
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'h80FF_1234;
    #2 chk("lb_wdata", bif.mem_to_wb_bus[31:0], 32'hFFFF_FF80);
    chk("lb_fwd_wdata", bif.mem_to_id_fwd[31:0], 32'hFFFF_FF80);
    bif.stall = '0;
    tick();
    bif.data_sram_rvalid = 1'b0;
  endtask

  task automatic test_half_bypass();
    bif.ex_to_mem_bus = mk(3'b011, 1'b1, 32'h0000_1002, 5'd7);
    tick();
    bif.ex_to_mem_bus = mk(3'b100, 1'b1, 32'h0000_1002, 5'd8);
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'h80FF_1234;
    #2 chk("lh_no_stall", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("lh_wdata", bif.mem_to_wb_bus[31:0], 32'hFFFF_80FF);
    tick();
    bif.ex_to_mem_bus = '0;
    #2 chk("lhu_no_stall", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("lhu_wdata", bif.mem_to_wb_bus[31:0], 32'h0000_80FF);
    tick();
    bif.data_sram_rvalid = 1'b0;
  endtask

  task automatic test_external_stall();
    enter(mk(3'b101, 1'b1, 32'h0000_2000, 5'd9));
    bif.stall = 6'b011111;
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'hDEAD_BEEF;
    #2 chk("ext_c0_req", {31'h0, bif.stall_req_mem}, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      bif.data_sram_rvalid = (i == 1);
      bif.data_sram_rdata  = 32'h1111_1111;
      #2 chk($sformatf("ext_hold%0d_req", i), {31'h0, bif.stall_req_mem}, 32'h0);
      chk($sformatf("ext_hold%0d_wdata", i), bif.mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
      tick();
    end
    bif.data_sram_rvalid = 1'b0;
    bif.stall = '0;
    #2 chk("ext_release_wdata", bif.mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
    chk("ext_release_rfwe", {31'h0, bif.mem_to_wb_bus[37]}, 32'h1);
    tick();
  endtask

  task automatic test_bubble_flush();
    enter(mk(3'b000, 1'b0, 32'h0000_0055, 5'd3));
    #2 chk("alu_wdata", bif.mem_to_wb_bus[31:0], 32'h0000_0055);
    bif.stall = 6'b001111;
    tick();
    bif.stall = '0;
    total_cnt++;
    if (bif.mem_to_wb_bus !== '0) $display("FAIL bubble_bus: got %h required 0", bif.mem_to_wb_bus);
    else begin pass_cnt++; $display("ok   bubble_bus"); end

    enter(mk(3'b101, 1'b1, 32'h0000_3000, 5'd4));
    bif.stall = 6'b011111;
    tick();
    #2 chk("flush_pre_req", {31'h0, bif.stall_req_mem}, 32'h1);
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0;
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'hCAFE_0000;
    #2 chk("flush_req", {31'h0, bif.stall_req_mem}, 32'h0);
    total_cnt++;
    if (bif.mem_to_wb_bus !== '0) $display("FAIL flush_bus: got %h required 0", bif.mem_to_wb_bus);
    else begin pass_cnt++; $display("ok   flush_bus"); end
    tick();
    bif.data_sram_rvalid = 1'b0;
    bif.stall = '0;
  endtask

  task automatic test_async_reset();
    enter(mk(3'b101, 1'b1, 32'h0000_4000, 5'd10));
    bif.stall = 6'b011111;
    tick();
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if (bif.mem_to_wb_bus !== '0 || bif.mem_to_id_fwd !== '0 || bif.stall_req_mem !== 1'b0)
      $display("FAIL async_reset: wb=%h fwd=%h req=%b required all 0",
               bif.mem_to_wb_bus, bif.mem_to_id_fwd, bif.stall_req_mem);
    else begin pass_cnt++; $display("ok   async_reset"); end
    #1 rst = 1'b1;
    tick();
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'h1234_5678;
    #2 chk("post_rst_req", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("post_rst_wdata", bif.mem_to_wb_bus[31:0], 32'h0);
    tick();
    bif.data_sram_rvalid = 1'b0;
    bif.stall = '0;
  endtask

  task automatic test_unaligned();
    enter(mk(3'b101, 1'b1, 32'h0000_1002, 5'd11));
`ifdef MEM_UNALIGNED_EXC_EN
    #2 chk("ua_req", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("ua_exc", {27'h0, bif.mem_to_wb_bus[140:136]}, 32'h4);
    chk("ua_badv", bif.mem_to_wb_bus[173:142], 32'h0000_1002);
    chk("ua_rfwe", {31'h0, bif.mem_to_wb_bus[37]}, 32'h0);
    tick();
`else
    bif.stall = 6'b011111;
    #2 chk("ua_req", {31'h0, bif.stall_req_mem}, 32'h1);
    tick();
    bif.data_sram_rvalid = 1'b1; bif.data_sram_rdata = 32'hA5A5_0F0F;
    #2 chk("ua_req_drop", {31'h0, bif.stall_req_mem}, 32'h0);
    chk("ua_wdata", bif.mem_to_wb_bus[31:0], 32'hA5A5_0F0F);
    chk("ua_exc", {27'h0, bif.mem_to_wb_bus[140:136]}, 32'h0);
    bif.stall = '0;
    tick();
    bif.data_sram_rvalid = 1'b0;
`endif
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_byte_wait();
    test_half_bypass();
    test_external_stall();
    test_bubble_flush();
    test_async_reset();
    test_unaligned();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
